// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//
// Streams a program into instruction memory and sequences the core reset.
// Words arrive on a valid/ready stream and are written sequentially from
// word address 0. The core is held in reset while loading and for
// HOLD_CYCLES cycles after the final write, then released. A program longer
// than DEPTH words parks the loader in an error state. A reload request
// restarts loading from RUN or ERR without a global reset.
//
// Ports:
//   clk_i         system clock, rising edge
//   reset_ni      asynchronous active-low reset
//   in_valid_i    upstream word valid
//   in_ready_o    loader accepts a word this cycle (registered)
//   in_data_i     instruction word
//   in_last_i     final word of the program, qualified by in_valid_i
//   reload_i      restart loading (honoured in RUN and ERR only)
//   imem_we_o     IMEM write strobe, one cycle after each transfer
//   imem_addr_o   IMEM word address
//   imem_wdata_o  IMEM write data
//   core_reset_o  active-high reset to the core
//   done_o        program loaded, core running
//   error_o       program overflowed IMEM
//   word_count_o  words written since the last load start
//
// state | meaning
// ------+------------------------------------------------------------
// LOAD  | accepting words from the stream
// HOLD  | program complete, core still in reset while the settle timer runs
// RUN   | core released, stream ignored, waiting for reload
// ERR   | overflow detected, core in reset, waiting for reload or reset

module imem_boot_loader #(
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       in_data_i,
    input  logic              in_last_i,
    input  logic              reload_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              core_reset_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W:0]   word_count_o
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [ADDR_W:0]  LAST_IDX  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]  FULL_CNT  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]  WC_ONE    = (ADDR_W + 1)'(1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic              in_ready_q;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   wcount_q, wcount_d;
    logic              core_reset_q;
    logic              done_q;
    logic              error_q;
    logic              xfer;

    assign xfer = in_valid_i && in_ready_q;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wcount_d   = wcount_q;

        // word_count doubles as the write pointer; it stops at DEPTH because
        // LOAD is left on the DEPTH-th transfer, the guard only keeps it honest.
        if (xfer) begin
            we_d    = 1'b1;
            addr_d  = wcount_q[ADDR_W-1:0];
            wdata_d = in_data_i;
            if (wcount_q != FULL_CNT) begin
                wcount_d = wcount_q + WC_ONE;
            end
        end

        case (state_q)
            ST_LOAD: begin
                if (xfer && in_last_i) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                end else if (xfer && (wcount_q == LAST_IDX)) begin
                    state_d = ST_ERR;
                end
            end
            ST_HOLD: begin
                // Loaded during the write cycle, so it reads HOLD_CYCLES-1 in
                // the first cycle after the write and hits zero on the last.
                if (hold_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_ONE;
                end
            end
            ST_RUN, ST_ERR: begin
                if (reload_i) begin
                    state_d  = ST_LOAD;
                    wcount_d = '0;
                    addr_d   = '0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Status outputs are registered from the next state so they line up with
    // the state they describe and never glitch.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= ST_LOAD;
            hold_cnt_q   <= '0;
            in_ready_q   <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wcount_q     <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            in_ready_q   <= (state_d == ST_LOAD);
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wcount_q     <= wcount_d;
            core_reset_q <= (state_d != ST_RUN);
            done_q       <= (state_d == ST_RUN);
            error_q      <= (state_d == ST_ERR);
        end
    end

    assign in_ready_o   = in_ready_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign core_reset_o = core_reset_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign word_count_o = wcount_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader (DEPTH=4 so overflow is reachable quickly).
module tb_imem_boot_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;
    localparam int HOLD   = 4;

    localparam int P_LOAD = 0;
    localparam int P_HOLD = 1;
    localparam int P_RUN  = 2;
    localparam int P_ERR  = 3;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_last  = 1'b0;
    logic              reload   = 1'b0;
    logic [31:0]       in_data  = '0;
    logic              in_ready_o;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_wdata_o;
    logic              core_reset_o;
    logic              done_o;
    logic              error_o;
    logic [ADDR_W:0]   word_count_o;

    imem_boot_loader #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk_i(clk), .reset_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready_o),
        .in_data_i(in_data), .in_last_i(in_last), .reload_i(reload),
        .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
        .core_reset_o(core_reset_o), .done_o(done_o), .error_o(error_o),
        .word_count_o(word_count_o)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase of the load, words accepted, and cycles of
    // reset remaining (write cycle plus HOLD settle cycles).
    int                m_phase = P_LOAD;
    bit                m_ready = 1'b0;
    bit                m_we    = 1'b0;
    logic [ADDR_W-1:0] m_addr  = '0;
    logic [31:0]       m_wdata = '0;
    int                m_count = 0;
    int                m_left  = 0;
    wire               m_acc   = in_valid && m_ready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= P_LOAD;
            m_ready <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_count <= 0;
            m_left  <= 0;
        end else begin
            m_we <= m_acc;
            if (m_acc) begin
                m_addr  <= m_count[ADDR_W-1:0];
                m_wdata <= in_data;
                m_count <= (m_count < DEPTH) ? m_count + 1 : m_count;
            end
            case (m_phase)
                P_LOAD: begin
                    if (m_acc && in_last) begin
                        m_phase <= P_HOLD;
                        m_left  <= HOLD + 1;
                        m_ready <= 1'b0;
                    end else if (m_acc && m_count == DEPTH - 1) begin
                        m_phase <= P_ERR;
                        m_ready <= 1'b0;
                    end else begin
                        m_ready <= 1'b1;
                    end
                end
                P_HOLD: begin
                    if (m_left == 1) m_phase <= P_RUN;
                    m_left <= m_left - 1;
                end
                default: begin
                    if (reload) begin
                        m_phase <= P_LOAD;
                        m_ready <= 1'b1;
                        m_count <= 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready_o, m_ready);
        chk("imem_we", imem_we_o, m_we);
        if (m_we) begin
            chk("imem_addr", imem_addr_o, m_addr);
            chk("imem_wdata", imem_wdata_o, m_wdata);
        end
        chk("word_count", word_count_o, 64'(m_count));
        chk("core_reset", core_reset_o, m_phase != P_RUN);
        chk("done", done_o, m_phase == P_RUN);
        chk("error", error_o, m_phase == P_ERR);
    end

    logic [31:0] dut_mem [0:255];
    int          wr_count = 0;

    always @(negedge clk) begin
        if (imem_we_o === 1'b1) begin
            dut_mem[imem_addr_o] <= imem_wdata_o;
            wr_count             <= wr_count + 1;
        end
    end

    task automatic clear_cap();
        wr_count = 0;
        for (int i = 0; i < 256; i++) dut_mem[i] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send(input logic [31:0] d, input logic last, input int budget, output bit ok);
        logic r;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int n = 0; n < budget; n++) begin
            r = in_ready_o;
            @(negedge clk);
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 40; i++) begin
            if (done_o) break;
            @(negedge clk);
        end
        chk(name, done_o, 1'b1);
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    initial begin
        bit ok;
        int cnt;
        logic [31:0] prog [0:2];
        prog[0] = 32'h0050_0093;
        prog[1] = 32'h0030_0113;
        prog[2] = 32'h0020_81B3;

        // 1: back-to-back load, hold length, release
        do_reset();
        clear_cap();
        chk("t1_reset_ready", in_ready_o, 1'b0);
        chk("t1_reset_core_reset", core_reset_o, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send(prog[i], i == 2, 10, ok);
            chk("t1_accept", ok, 1'b1);
        end
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (core_reset_o) cnt++;
            else break;
        end
        chk("t1_hold_cycles", cnt, 4);
        chk("t1_done", done_o, 1'b1);
        chk("t1_word_count", word_count_o, 3);
        chk("t1_writes", wr_count, 3);
        chk("t1_mem0", dut_mem[0], 32'h0050_0093);
        chk("t1_mem1", dut_mem[1], 32'h0030_0113);
        chk("t1_mem2", dut_mem[2], 32'h0020_81B3);

        // 2: gaps of two idle cycles between words
        do_reset();
        clear_cap();
        for (int i = 0; i < 3; i++) begin
            send(prog[i], i == 2, 10, ok);
            chk("t2_accept", ok, 1'b1);
            if (i < 2) idle(2);
        end
        wait_done("t2_done");
        chk("t2_writes", wr_count, 3);
        chk("t2_mem0", dut_mem[0], 32'h0050_0093);
        chk("t2_mem2", dut_mem[2], 32'h0020_81B3);

        // 3: overflow with five words and no in_last
        do_reset();
        clear_cap();
        for (int i = 0; i < 4; i++) begin
            send(32'h11 * (i + 1), 1'b0, 10, ok);
            chk("t3_accept", ok, 1'b1);
        end
        send(32'h55, 1'b0, 8, ok);
        chk("t3_fifth_refused", ok, 1'b0);
        chk("t3_error", error_o, 1'b1);
        chk("t3_ready", in_ready_o, 1'b0);
        chk("t3_core_reset", core_reset_o, 1'b1);
        chk("t3_done", done_o, 1'b0);
        chk("t3_writes", wr_count, 4);
        chk("t3_word_count", word_count_o, 4);
        chk("t3_mem0", dut_mem[0], 32'h11);
        chk("t3_mem3", dut_mem[3], 32'h44);

        // 3b: reload out of ERR
        pulse_reload();
        chk("t3b_error_clear", error_o, 1'b0);
        chk("t3b_word_count", word_count_o, 0);
        clear_cap();
        send(32'hCAFE_0001, 1'b1, 10, ok);
        chk("t3b_accept", ok, 1'b1);
        wait_done("t3b_done");
        chk("t3b_mem0", dut_mem[0], 32'hCAFE_0001);

        // 4: exact fit of DEPTH words
        do_reset();
        clear_cap();
        for (int i = 0; i < 4; i++) begin
            send(32'hA0 + i, i == 3, 10, ok);
            chk("t4_accept", ok, 1'b1);
        end
        wait_done("t4_done");
        chk("t4_error", error_o, 1'b0);
        chk("t4_word_count", word_count_o, 4);
        chk("t4_writes", wr_count, 4);
        chk("t4_mem3", dut_mem[3], 32'hA3);

        // 5: reload from RUN
        pulse_reload();
        chk("t5_core_reset", core_reset_o, 1'b1);
        chk("t5_done", done_o, 1'b0);
        chk("t5_word_count", word_count_o, 0);
        chk("t5_ready", in_ready_o, 1'b1);
        clear_cap();
        send(32'hBEEF_0000, 1'b0, 10, ok);
        chk("t5_accept", ok, 1'b1);
        send(32'hBEEF_0001, 1'b1, 10, ok);
        chk("t5_accept", ok, 1'b1);
        wait_done("t5_done_after");
        chk("t5_word_count_after", word_count_o, 2);
        chk("t5_writes", wr_count, 2);
        chk("t5_mem0", dut_mem[0], 32'hBEEF_0000);
        chk("t5_mem1", dut_mem[1], 32'hBEEF_0001);

        // 6: reset in the middle of HOLD, then a fresh load
        do_reset();
        clear_cap();
        for (int i = 0; i < 3; i++) begin
            send(prog[i], i == 2, 10, ok);
            chk("t6_accept", ok, 1'b1);
        end
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", in_ready_o, 1'b0);
        chk("t6_rst_we", imem_we_o, 1'b0);
        chk("t6_rst_addr", imem_addr_o, 0);
        chk("t6_rst_wdata", imem_wdata_o, 0);
        chk("t6_rst_core_reset", core_reset_o, 1'b1);
        chk("t6_rst_done", done_o, 1'b0);
        chk("t6_rst_error", error_o, 1'b0);
        chk("t6_rst_word_count", word_count_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_cap();
        send(32'hAAAA_0001, 1'b0, 10, ok);
        chk("t6_accept2", ok, 1'b1);
        send(32'hAAAA_0002, 1'b1, 10, ok);
        chk("t6_accept2", ok, 1'b1);
        wait_done("t6_done");
        chk("t6_mem0", dut_mem[0], 32'hAAAA_0001);
        chk("t6_mem1", dut_mem[1], 32'hAAAA_0002);
        chk("t6_word_count", word_count_o, 2);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sits upstream of the single-cycle core top. It receives a program as a valid/ready stream of 32-bit instruction words and writes them sequentially into instruction memory starting at word address 0.
- It holds the core in reset while loading and for a fixed settle period, then releases the core.
- It flags overflow (program longer than memory) and supports a reload request without a global reset.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- DEPTH, 256, number of IMEM words; must be <= 2**ADDR_W.
- HOLD_CYCLES, 4, cycles core_reset stays high after the last write before release; must be >= 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  loader can accept a word this cycle.
- in_data  input  32  instruction word.
- in_last  input  1  marks the final word of the program; qualified by in_valid.
- reload  input  1  single-cycle request to restart loading; honoured only in RUN or ERR.
- imem_we  output  1  IMEM write strobe.
- imem_addr  output  ADDR_W  IMEM word address.
- imem_wdata  output  32  IMEM write data.
- core_reset  output  1  active-high reset to the core top.
- done  output  1  program loaded, core running.
- error  output  1  overflow detected.
- word_count  output  ADDR_W+1  words written since the last load start.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately):
  - state=LOAD, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - core_reset=1, done=0, error=0, word_count=0.
- in_ready: equals (state==LOAD) and is registered. It first goes high on the first clock edge after reset deasserts.
- Transfer: occurs when in_valid and in_ready are both high at a rising edge.
- Write latency:
  - The cycle after a transfer, imem_we=1 for exactly one cycle, with imem_addr = the current write pointer and imem_wdata = the accepted in_data.
  - The pointer and word_count increment in that same cycle. The first word goes to address 0.
- Back-to-back transfers every cycle are supported: one write per cycle, no bubbles.
- States:
  - LOAD: accept words.
    - Transfer with in_last=1 -> HOLD, and in_ready drops next cycle.
    - Transfer of word number DEPTH with in_last=0 -> ERR. That word is still written to address DEPTH-1.
    - Transfer of word DEPTH with in_last=1 -> HOLD (exact fit, not an error).
  - HOLD: in_ready=0, core_reset=1. The counter starts at 0 the cycle after the final imem_we. After HOLD_CYCLES cycles -> RUN.
  - RUN: core_reset=0, done=1, in_ready=0. in_valid is ignored and no writes occur. reload=1 -> LOAD.
  - ERR: error=1, core_reset=1, done=0, in_ready=0. reload=1 -> LOAD; otherwise only reset exits.
- Reload (from RUN or ERR), at the next edge:
  - core_reset=1, done=0, error=0.
  - Pointer and word_count clear to 0. in_ready=1 on the following cycle.
  - reload is ignored in LOAD and HOLD.
- in_last without in_valid has no effect.
- Inputs are held stable by upstream while in_valid=1 and in_ready=0; the loader does not check this.
- Reset asserted mid-load or mid-HOLD: returns immediately to reset values. Partially written IMEM contents are not cleared.
- word_count saturates at DEPTH. The pointer never wraps.

Test Plan:
1. Reset low 3 cycles, release, stream 3 words (0x00500093, 0x00300113, 0x002081B3) back-to-back with in_last on the 3rd -> imem_we on 3 consecutive cycles at addr 0,1,2 with matching data. word_count=3. core_reset stays 1 for exactly 4 cycles after the last write, then core_reset=0 and done=1.
2. Same 3 words with in_valid low between words (gap of 2 cycles) -> writes only on the cycles after each transfer, addresses still 0,1,2, no spurious imem_we.
3. DEPTH=4, stream 5 words with no in_last -> 4 writes (addr 0..3), error=1 after the 4th transfer, in_ready=0, 5th word never written, core_reset stays 1.
4. DEPTH=4, 4 words with in_last on the 4th -> no error, done=1 after HOLD, word_count=4.
5. In RUN, pulse reload, then stream 2 words with in_last -> core_reset=1 the cycle after reload, done=0, writes to addr 0 and 1, word_count=2, done=1 after HOLD.
6. Assert reset during the HOLD count (HOLD_CYCLES=4, after 2 hold cycles) -> outputs immediately take reset values and core_reset remains 1. A full reload sequence afterward succeeds from addr 0.
